// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card responder for CMD0/8/55/41/17.
// Ports: clk/rst system; sd_ck/sd_csn/sd_mosi/sd_miso SPI pins;
//   cmd_valid/cmd_idx/cmd_arg last command; init_done card ready;
//   blk_addr/byte_idx/byte_data block fetch; rd_busy read in flight.

module sd_spi_responder #(
   parameter int NAC_BYTES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sd_ck,
   input  logic        sd_csn,
   input  logic        sd_mosi,
   output logic        sd_miso,
   output logic        cmd_valid,
   output logic [5:0]  cmd_idx,
   output logic [31:0] cmd_arg,
   output logic        init_done,
   output logic [31:0] blk_addr,
   output logic [8:0]  byte_idx,
   input  logic [7:0]  byte_data,
   output logic        rd_busy
);

   typedef enum logic [2:0] {
      IDLE, RX_CMD, NCR, TX_RESP, NAC, TX_TOKEN, TX_DATA, TX_CRC
   } state_t;

   localparam logic [8:0] NAC_LAST = 9'(NAC_BYTES - 1);

   logic [1:0] ck_s;
   logic [1:0] csn_s;
   logic [1:0] mosi_s;
   logic       ck_d;
   logic       ck_rise;
   logic       ck_fall;
   logic       csn;
   logic       mosi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ck_s   <= 2'b00;
         csn_s  <= 2'b11;
         mosi_s <= 2'b11;
         ck_d   <= 1'b0;
      end else begin
         ck_s   <= {ck_s[0], sd_ck};
         csn_s  <= {csn_s[0], sd_csn};
         mosi_s <= {mosi_s[0], sd_mosi};
         ck_d   <= ck_s[1];
      end
   end

   assign ck_rise = ck_s[1] & ~ck_d;
   assign ck_fall = ~ck_s[1] & ck_d;
   assign csn     = csn_s[1];
   assign mosi    = mosi_s[1];

   state_t      state;
   logic [6:0]  win;
   logic [37:0] sr;
   logic [5:0]  rx_cnt;
   logic [2:0]  bit_cnt;
   logic [8:0]  byte_cnt;
   logic [7:0]  tx_byte;
   logic [7:0]  nxt_byte;
   logic [7:0]  r1;
   logic        long_resp;
   logic        in_idle;
   logic        app_flag;
   logic [2:0]  fetch_p;

   assign init_done = ~in_idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         win       <= 7'h7F;
         sr        <= '0;
         rx_cnt    <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         tx_byte   <= 8'hFF;
         nxt_byte  <= '0;
         r1        <= '0;
         long_resp <= 1'b0;
         in_idle   <= 1'b1;
         app_flag  <= 1'b0;
         fetch_p   <= '0;
         sd_miso   <= 1'b1;
         cmd_valid <= 1'b0;
         cmd_idx   <= '0;
         cmd_arg   <= '0;
         blk_addr  <= '0;
         byte_idx  <= '0;
         rd_busy   <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         // byte_data settles 2 clk after byte_idx moves; take it on the 3rd
         fetch_p <= {fetch_p[1:0], 1'b0};
         if (fetch_p[2]) nxt_byte <= byte_data;

         if (csn) begin
            state   <= IDLE;
            sd_miso <= 1'b1;
            rd_busy <= 1'b0;
            win     <= 7'h7F;
            bit_cnt <= '0;
         end else if (ck_rise) begin
            case (state)
               IDLE: begin
                  // window plus this bit starts with 01: frame start
                  if (win[6:5] == 2'b01) begin
                     state  <= RX_CMD;
                     sr     <= {32'h0, win[4:0], mosi};
                     rx_cnt <= 6'd8;
                     win    <= 7'h7F;
                  end else begin
                     win <= {win[5:0], mosi};
                  end
               end
               RX_CMD: begin
                  rx_cnt <= rx_cnt + 6'd1;
                  // only index and argument are kept; CRC byte drops
                  if (rx_cnt < 6'd40) sr <= {sr[36:0], mosi};
                  if (rx_cnt == 6'd47) begin
                     cmd_valid <= 1'b1;
                     cmd_idx   <= sr[37:32];
                     cmd_arg   <= sr[31:0];
                     state     <= NCR;
                     tx_byte   <= 8'hFF;
                     bit_cnt   <= '0;
                     long_resp <= 1'b0;
                     app_flag  <= 1'b0;
                     unique case (1'b1)
                        (sr[37:32] == 6'd0): begin
                           in_idle <= 1'b1;
                           r1      <= 8'h01;
                        end
                        (sr[37:32] == 6'd8): begin
                           r1        <= {7'h0, in_idle};
                           long_resp <= 1'b1;
                        end
                        (sr[37:32] == 6'd55): begin
                           app_flag <= 1'b1;
                           r1       <= {7'h0, in_idle};
                        end
                        (sr[37:32] == 6'd41 && app_flag): begin
                           in_idle <= 1'b0;
                           r1      <= 8'h00;
                        end
                        (sr[37:32] == 6'd17 && !in_idle): begin
                           rd_busy  <= 1'b1;
                           blk_addr <= sr[31:0];
                           byte_idx <= '0;
                           fetch_p  <= {fetch_p[1:0], 1'b1};
                           r1       <= 8'h00;
                        end
                        default: r1 <= {5'h0, 1'b1, 1'b0, in_idle};
                     endcase
                  end
               end
               default: ;
            endcase
         end else if (ck_fall) begin
            if (state == IDLE || state == RX_CMD) begin
               sd_miso <= 1'b1;
            end else begin
               sd_miso <= tx_byte[3'd7 - bit_cnt];
               bit_cnt <= bit_cnt + 3'd1;
               // start fetching the following byte as this one begins
               if (state == TX_DATA && bit_cnt == 3'd0 &&
                   byte_cnt != 9'd511) begin
                  byte_idx <= byte_cnt + 9'd1;
                  fetch_p  <= {fetch_p[1:0], 1'b1};
               end
               if (bit_cnt == 3'd7) begin
                  case (state)
                     NCR: begin
                        state    <= TX_RESP;
                        tx_byte  <= r1;
                        byte_cnt <= '0;
                     end
                     TX_RESP: begin
                        if (long_resp && byte_cnt != 9'd4) begin
                           byte_cnt <= byte_cnt + 9'd1;
                           case (byte_cnt)
                              9'd2:    tx_byte <= 8'h01;
                              9'd3:    tx_byte <= cmd_arg[7:0];
                              default: tx_byte <= 8'h00;
                           endcase
                        end else if (rd_busy) begin
                           byte_cnt <= '0;
                           if (NAC_BYTES > 0) begin
                              state   <= NAC;
                              tx_byte <= 8'hFF;
                           end else begin
                              state   <= TX_TOKEN;
                              tx_byte <= 8'hFE;
                           end
                        end else begin
                           state <= IDLE;
                        end
                     end
                     NAC: begin
                        if (byte_cnt == NAC_LAST) begin
                           state   <= TX_TOKEN;
                           tx_byte <= 8'hFE;
                        end else begin
                           byte_cnt <= byte_cnt + 9'd1;
                        end
                     end
                     TX_TOKEN: begin
                        state    <= TX_DATA;
                        tx_byte  <= nxt_byte;
                        byte_cnt <= '0;
                     end
                     TX_DATA: begin
                        if (byte_cnt == 9'd511) begin
                           state    <= TX_CRC;
                           tx_byte  <= 8'h00;
                           byte_cnt <= '0;
                        end else begin
                           tx_byte  <= nxt_byte;
                           byte_cnt <= byte_cnt + 9'd1;
                        end
                     end
                     TX_CRC: begin
                        if (byte_cnt == 9'd1) begin
                           state   <= IDLE;
                           rd_busy <= 1'b0;
                        end else begin
                           byte_cnt <= byte_cnt + 9'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: host-side SPI driver with a queue-based
// response model for sd_spi_responder.

module tb_sd_spi_responder;

   localparam int NAC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sd_ck = 1'b0;
   logic        sd_csn = 1'b1;
   logic        sd_mosi = 1'b1;
   logic        sd_miso;
   logic        cmd_valid;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg;
   logic        init_done;
   logic [31:0] blk_addr;
   logic [8:0]  byte_idx;
   logic [7:0]  byte_data;
   logic        rd_busy;

   logic [7:0]  mem_p1;
   int          n_chk = 0;
   int          n_err = 0;
   int          n_valid = 0;
   int          half_ns = 42;
   bit          m_idle = 1'b1;
   bit          m_app = 1'b0;
   logic [7:0]  exp_q[$];

   sd_spi_responder #(.NAC_BYTES(NAC)) dut (
      .clk(clk),
      .rst(rst),
      .sd_ck(sd_ck),
      .sd_csn(sd_csn),
      .sd_mosi(sd_mosi),
      .sd_miso(sd_miso),
      .cmd_valid(cmd_valid),
      .cmd_idx(cmd_idx),
      .cmd_arg(cmd_arg),
      .init_done(init_done),
      .blk_addr(blk_addr),
      .byte_idx(byte_idx),
      .byte_data(byte_data),
      .rd_busy(rd_busy)
   );

   always #5 clk = ~clk;

   // block memory with two clocks of read latency
   always @(posedge clk) begin
      mem_p1    <= byte_idx[7:0];
      byte_data <= mem_p1;
   end

   always @(negedge clk) if (cmd_valid) n_valid++;

   initial begin
      #900000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      half_ns = $urandom_range(41, 44);
      for (int i = 7; i >= 0; i--) begin
         sd_mosi = tx[i];
         #(half_ns);
         rx[i] = sd_miso;
         sd_ck = 1'b1;
         #(half_ns);
         sd_ck = 1'b0;
      end
   endtask

   // stop_kind: 0 run to end, 1 csn abort, 2 rst pulse at stop_at
   task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] crc, input int stop_at,
                         input int stop_kind);
      logic [47:0] frame;
      logic [7:0]  rx;
      int          v0;
      bit          rd;
      rd = 1'b0;
      exp_q.delete();
      exp_q.push_back(8'hFF);
      if (idx == 6'd0) begin
         m_idle = 1'b1;
         exp_q.push_back(8'h01);
      end else if (idx == 6'd8) begin
         exp_q.push_back({7'd0, m_idle});
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h01);
         exp_q.push_back(arg[7:0]);
      end else if (idx == 6'd55) begin
         exp_q.push_back({7'd0, m_idle});
      end else if (idx == 6'd41 && m_app) begin
         m_idle = 1'b0;
         exp_q.push_back(8'h00);
      end else if (idx == 6'd17 && !m_idle) begin
         rd = 1'b1;
         exp_q.push_back(8'h00);
         repeat (NAC) exp_q.push_back(8'hFF);
         exp_q.push_back(8'hFE);
         for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
      end else begin
         exp_q.push_back({5'd0, 1'b1, 1'b0, m_idle});
      end
      m_app = (idx == 6'd55);

      frame = {2'b01, idx, arg, crc};
      v0 = n_valid;
      for (int b = 5; b >= 0; b--) xfer(frame[b*8 +: 8], rx);
      check("valid_pulse", 32'(n_valid - v0), 32'd1);
      check("cmd_idx", 32'(cmd_idx), 32'(idx));
      check("cmd_arg", cmd_arg, arg);
      check("rd_busy", 32'(rd_busy), 32'(rd));
      if (rd) check("blk_addr", blk_addr, arg);

      for (int k = 0; k < exp_q.size(); k++) begin
         if (k == stop_at && stop_kind == 1) begin
            sd_csn = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check("csn_miso", 32'(sd_miso), 32'd1);
            check("csn_busy", 32'(rd_busy), 32'd0);
            repeat (4) @(posedge clk);
            sd_csn = 1'b0;
            repeat (4) @(posedge clk);
            return;
         end
         if (k == stop_at && stop_kind == 2) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("rst_miso", 32'(sd_miso), 32'd1);
            check("rst_init", 32'(init_done), 32'd0);
            check("rst_idx", 32'(cmd_idx), 32'd0);
            check("rst_busy", 32'(rd_busy), 32'd0);
            m_idle = 1'b1;
            m_app  = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (4) @(posedge clk);
            return;
         end
         xfer(8'hFF, rx);
         check($sformatf("rsp%0d_idx%0d", k, idx), 32'(rx), 32'(exp_q[k]));
      end
      xfer(8'hFF, rx);
      check("tail_ff", 32'(rx), 32'hFF);
      check("tail_busy", 32'(rd_busy), 32'd0);
      check("init_done", 32'(init_done), 32'(!m_idle));
   endtask

   initial begin
      logic [7:0]  rx;
      logic [5:0]  idx;
      logic [31:0] arg;
      int          sel;
      int          stop_at;
      int          kind;

      repeat (3) @(posedge clk);
      #1;
      check("rst_miso0", 32'(sd_miso), 32'd1);
      check("rst_valid0", 32'(cmd_valid), 32'd0);
      check("rst_idx0", 32'(cmd_idx), 32'd0);
      check("rst_arg0", cmd_arg, 32'd0);
      check("rst_init0", 32'(init_done), 32'd0);
      check("rst_blk0", blk_addr, 32'd0);
      check("rst_bidx0", 32'(byte_idx), 32'd0);
      check("rst_busy0", 32'(rd_busy), 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      sd_csn = 1'b0;
      repeat (4) @(posedge clk);
      xfer(8'hFF, rx);
      check("idle_ff", 32'(rx), 32'hFF);

      do_cmd(6'd0, 32'h0, 8'h95, -1, 0);
      do_cmd(6'd8, 32'h000001AA, 8'h87, -1, 0);
      do_cmd(6'd17, 32'h10, 8'hFF, -1, 0);
      do_cmd(6'd55, 32'h0, 8'hFF, -1, 0);
      do_cmd(6'd41, 32'h40000000, 8'hFF, -1, 0);
      do_cmd(6'd17, 32'h10, 8'hFF, -1, 0);
      do_cmd(6'd17, 32'h2000, 8'hFF, 5 + NAC + 100 - 2, 1);
      do_cmd(6'd0, 32'h0, 8'h95, -1, 0);
      do_cmd(6'd55, 32'h0, 8'hFF, -1, 0);
      do_cmd(6'd41, 32'h40000000, 8'hFF, -1, 0);
      do_cmd(6'd8, 32'h000001AA, 8'h87, 4, 2);
      do_cmd(6'd0, 32'h0, 8'h95, -1, 0);

      for (int n = 0; n < 16; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: idx = 6'd0;
            1: idx = 6'd8;
            2: idx = 6'd17;
            3: idx = 6'd41;
            4: idx = 6'd55;
            default: idx = 6'($urandom_range(0, 63));
         endcase
         arg = $urandom;
         stop_at = -1;
         kind = 0;
         if (idx == 6'd17 && !m_idle) begin
            stop_at = 3 + NAC + $urandom_range(0, 12);
            kind = $urandom_range(1, 2);
         end
         do_cmd(idx, arg, 8'($urandom), stop_at, kind);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
